fpga_input_conditioner: RTL and testbench

//  Board-input front end feeding the lotr core's Button_0/Button_1/Switch inputs on the FPGA top.

---
 rtl/fpga_io_pkg.sv | 17 +
 rtl/btn_debounce.sv | 114 +++++++++++
 rtl/fpga_input_conditioner.sv | 99 +++++++++
 tb/tb_fpga_input_conditioner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_io_pkg.sv
// Shared types and default timing constants for the board-input front end.
// Defaults assume QClk runs at 50 kHz.
package fpga_io_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms of stability before a change is accepted
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 500;
    // 1 s of holding after the press before a long-press pulse
    localparam int DEFAULT_LONG_PRESS_CYCLES = 50000;

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchroniser, debounce FSM and long-press timer.
// The raw pin is active-low; all outputs use 1 = pressed.
module btn_debounce
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES - 1);

    logic            sync_1;
    logic            sync_2;
    logic            pressed_synced;
    btn_state_t      state;
    logic [DB_W-1:0] cnt;
    logic [LP_W-1:0] long_cnt;
    logic            long_done;

    // Synchroniser resets to 1 so a held-down button is not seen during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= button_raw_n;
            sync_2 <= sync_1;
        end
    end

    assign pressed_synced = ~sync_2;

    // Debounce FSM; long_done keeps BtnLong to a single pulse per press,
    // even across a bounce through RELEASE_WAIT back into PRESSED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            cnt           <= '0;
            long_cnt      <= '0;
            long_done     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                RELEASED: begin
                    if (pressed_synced) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_synced) begin
                        state <= RELEASED;
                    end else if (cnt == DB_MAX) begin
                        state       <= PRESSED;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        long_cnt    <= '0;
                        long_done   <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (long_cnt != LP_MAX) begin
                        long_cnt <= long_cnt + 1'b1;
                    end else if (!long_done) begin
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                    end
                    if (!pressed_synced) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_synced) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_MAX) begin
                        state         <= RELEASED;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpga_input_conditioner.sv
// Board-input front end for the lotr core: synchronises and debounces the
// push buttons and slide switches into the QClk domain and emits clean
// levels plus single-cycle event pulses.
module fpga_input_conditioner
    import fpga_io_pkg::*;
#(
    parameter int NUM_BTN           = 2,
    parameter int NUM_SW            = 10,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic               QClk,
    input  logic               RstQnnnH,
    input  logic [NUM_BTN-1:0] ButtonRawN,
    input  logic [NUM_SW-1:0]  SwitchRaw,
    output logic [NUM_BTN-1:0] BtnLevel,
    output logic [NUM_BTN-1:0] BtnPress,
    output logic [NUM_BTN-1:0] BtnRelease,
    output logic [NUM_BTN-1:0] BtnLong,
    output logic [NUM_SW-1:0]  SwLevel,
    output logic [NUM_SW-1:0]  SwChange
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_btn (
            .clk          (QClk),
            .rst          (RstQnnnH),
            .button_raw_n (ButtonRawN[b]),
            .level        (BtnLevel[b]),
            .press_pulse  (BtnPress[b]),
            .release_pulse(BtnRelease[b]),
            .long_pulse   (BtnLong[b])
        );
    end

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        logic            sync_1;
        logic            sync_2;
        logic            waiting;
        logic            level_q;
        logic            change_q;
        logic [DB_W-1:0] cnt;

        // Two-flop synchroniser for the asynchronous switch pin.
        always_ff @(posedge QClk) begin
            if (RstQnnnH) begin
                sync_1 <= 1'b0;
                sync_2 <= 1'b0;
            end else begin
                sync_1 <= SwitchRaw[s];
                sync_2 <= sync_1;
            end
        end

        // Debounce: the first differing cycle arms the counter, so switches
        // see exactly the same latency as buttons; any agreeing cycle disarms.
        always_ff @(posedge QClk) begin
            if (RstQnnnH) begin
                waiting  <= 1'b0;
                cnt      <= '0;
                level_q  <= 1'b0;
                change_q <= 1'b0;
            end else begin
                change_q <= 1'b0;
                if (sync_2 == level_q) begin
                    waiting <= 1'b0;
                    cnt     <= '0;
                end else if (!waiting) begin
                    waiting <= 1'b1;
                    cnt     <= '0;
                end else if (cnt == DB_MAX) begin
                    level_q  <= ~level_q;
                    change_q <= 1'b1;
                    waiting  <= 1'b0;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign SwLevel[s]  = level_q;
        assign SwChange[s] = change_q;
    end

endmodule

// File: tb/tb_fpga_input_conditioner.sv
// Self-checking bench for fpga_input_conditioner with short debounce and
// long-press times. A streak-based reference model predicts every output.
module tb_fpga_input_conditioner;

    localparam int NB = 2;
    localparam int NS = 10;
    localparam int DB = 4;
    localparam int LP = 20;

    logic          QClk;
    logic          RstQnnnH;
    logic [NB-1:0] ButtonRawN;
    logic [NS-1:0] SwitchRaw;
    logic [NB-1:0] BtnLevel;
    logic [NB-1:0] BtnPress;
    logic [NB-1:0] BtnRelease;
    logic [NB-1:0] BtnLong;
    logic [NS-1:0] SwLevel;
    logic [NS-1:0] SwChange;

    int nVectors = 0;
    int nMiscompares = 0;
    int edgeNum = 0;

    logic [NB-1:0] mBtnLevel = '0;
    logic [NB-1:0] mBtnPress = '0;
    logic [NB-1:0] mBtnRelease = '0;
    logic [NB-1:0] mBtnLong = '0;
    logic [NS-1:0] mSwLevel = '0;
    logic [NS-1:0] mSwChange = '0;

    fpga_input_conditioner #(
        .NUM_BTN          (NB),
        .NUM_SW           (NS),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .QClk      (QClk),
        .RstQnnnH  (RstQnnnH),
        .ButtonRawN(ButtonRawN),
        .SwitchRaw (SwitchRaw),
        .BtnLevel  (BtnLevel),
        .BtnPress  (BtnPress),
        .BtnRelease(BtnRelease),
        .BtnLong   (BtnLong),
        .SwLevel   (SwLevel),
        .SwChange  (SwChange)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNum, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] btn, input logic [NS-1:0] sw,
                                 input logic rst, output int firstEdge);
        ButtonRawN = btn;
        SwitchRaw  = sw;
        RstQnnnH   = rst;
        firstEdge  = edgeNum + 1;
    endtask

    task automatic gotoEdge(input int e);
        while (edgeNum < e) begin
            @(posedge QClk);
            #1;
        end
    endtask

    // Reference model: an input is accepted once the synchronised value has
    // disagreed with the debounced level on DB+1 consecutive edges. The
    // synchronised value seen at an edge is the raw value sampled two edges
    // earlier. Long press counts edges spent settled in the pressed level.
    initial begin
        bit obs;
        bit bH1 [NB];
        bit bH2 [NB];
        int bStreak [NB];
        int bLong [NB];
        bit bFired [NB];
        bit sH1 [NS];
        bit sH2 [NS];
        int sStreak [NS];
        for (int i = 0; i < NB; i++) begin
            bH1[i] = 0; bH2[i] = 0; bStreak[i] = 0; bLong[i] = 0; bFired[i] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            sH1[i] = 0; sH2[i] = 0; sStreak[i] = 0;
        end
        forever begin
            @(posedge QClk);
            edgeNum++;
            mBtnPress   = '0;
            mBtnRelease = '0;
            mBtnLong    = '0;
            mSwChange   = '0;
            if (RstQnnnH) begin
                mBtnLevel = '0;
                mSwLevel  = '0;
                for (int i = 0; i < NB; i++) begin
                    bH1[i] = 0; bH2[i] = 0; bStreak[i] = 0; bLong[i] = 0; bFired[i] = 0;
                end
                for (int i = 0; i < NS; i++) begin
                    sH1[i] = 0; sH2[i] = 0; sStreak[i] = 0;
                end
            end else begin
                for (int i = 0; i < NB; i++) begin
                    obs    = bH2[i];
                    bH2[i] = bH1[i];
                    bH1[i] = ~ButtonRawN[i];
                    if (mBtnLevel[i] && bStreak[i] == 0) begin
                        if (bLong[i] == LP - 1 && !bFired[i]) begin
                            mBtnLong[i] = 1'b1;
                            bFired[i]   = 1;
                        end
                        if (bLong[i] < LP - 1) bLong[i]++;
                    end
                    if (obs != mBtnLevel[i]) begin
                        bStreak[i]++;
                        if (bStreak[i] == DB + 1) begin
                            bStreak[i]   = 0;
                            mBtnLevel[i] = obs;
                            if (obs) begin
                                mBtnPress[i] = 1'b1;
                                bLong[i]     = 0;
                                bFired[i]    = 0;
                            end else begin
                                mBtnRelease[i] = 1'b1;
                            end
                        end
                    end else begin
                        bStreak[i] = 0;
                    end
                end
                for (int i = 0; i < NS; i++) begin
                    obs    = sH2[i];
                    sH2[i] = sH1[i];
                    sH1[i] = SwitchRaw[i];
                    if (obs != mSwLevel[i]) begin
                        sStreak[i]++;
                        if (sStreak[i] == DB + 1) begin
                            sStreak[i]   = 0;
                            mSwLevel[i]  = obs;
                            mSwChange[i] = 1'b1;
                        end
                    end else begin
                        sStreak[i] = 0;
                    end
                end
            end
        end
    end

    // Every cycle, away from the active edge, compare the DUT to the model.
    initial begin
        forever begin
            @(negedge QClk);
            checkOutput("model_BtnLevel",   32'(BtnLevel),   32'(mBtnLevel));
            checkOutput("model_BtnPress",   32'(BtnPress),   32'(mBtnPress));
            checkOutput("model_BtnRelease", 32'(BtnRelease), 32'(mBtnRelease));
            checkOutput("model_BtnLong",    32'(BtnLong),    32'(mBtnLong));
            checkOutput("model_SwLevel",    32'(SwLevel),    32'(mSwLevel));
            checkOutput("model_SwChange",   32'(SwChange),   32'(mSwChange));
        end
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations (latency DB+2 = 6).
    initial begin
        int e0, e1, e2, r, e3, e4, e5, e6, e7, e8, dummy;
        ButtonRawN = 2'b00;
        SwitchRaw  = '0;
        RstQnnnH   = 1'b1;
        repeat (3) begin
            @(posedge QClk);
            #1;
            checkOutput("reset_BtnLevel", 32'(BtnLevel), 32'h0);
            checkOutput("reset_BtnPress", 32'(BtnPress), 32'h0);
            checkOutput("reset_SwLevel",  32'(SwLevel),  32'h0);
        end

        $display("[TB] both buttons held through reset");
        applyStimulus(2'b00, '0, 1'b0, e0);
        gotoEdge(e0 + 5);
        checkOutput("t1_press_early", 32'(BtnPress), 32'h0);
        gotoEdge(e0 + 6);
        checkOutput("t1_press", 32'(BtnPress), 32'h3);
        checkOutput("t1_level", 32'(BtnLevel), 32'h3);
        applyStimulus(2'b11, '0, 1'b0, e1);
        gotoEdge(e1 + 6);
        checkOutput("t1_release", 32'(BtnRelease), 32'h3);
        checkOutput("t1_level_off", 32'(BtnLevel), 32'h0);
        gotoEdge(e1 + 8);

        $display("[TB] long press on button 0");
        applyStimulus(2'b10, '0, 1'b0, e2);
        gotoEdge(e2 + 5);
        checkOutput("t2_press_early", 32'(BtnPress), 32'h0);
        gotoEdge(e2 + 6);
        checkOutput("t2_press", 32'(BtnPress), 32'h1);
        checkOutput("t2_level", 32'(BtnLevel), 32'h1);
        gotoEdge(e2 + 7);
        checkOutput("t2_press_once", 32'(BtnPress), 32'h0);
        gotoEdge(e2 + 25);
        checkOutput("t2_long_early", 32'(BtnLong), 32'h0);
        gotoEdge(e2 + 26);
        checkOutput("t2_long", 32'(BtnLong), 32'h1);
        gotoEdge(e2 + 27);
        checkOutput("t2_long_once", 32'(BtnLong), 32'h0);
        gotoEdge(e2 + 60);
        checkOutput("t2_level_held", 32'(BtnLevel), 32'h1);

        $display("[TB] release bounce then real release on button 0");
        applyStimulus(2'b11, '0, 1'b0, r);
        gotoEdge(r + 1);
        applyStimulus(2'b10, '0, 1'b0, dummy);
        gotoEdge(r + 10);
        checkOutput("t4_level_kept", 32'(BtnLevel), 32'h1);
        checkOutput("t4_no_release", 32'(BtnRelease), 32'h0);
        applyStimulus(2'b11, '0, 1'b0, e3);
        gotoEdge(e3 + 5);
        checkOutput("t4_release_early", 32'(BtnRelease), 32'h0);
        gotoEdge(e3 + 6);
        checkOutput("t4_release", 32'(BtnRelease), 32'h1);
        checkOutput("t4_level_off", 32'(BtnLevel), 32'h0);
        gotoEdge(e3 + 8);

        $display("[TB] press bounce on button 1");
        applyStimulus(2'b01, '0, 1'b0, e4);
        gotoEdge(e4 + 2);
        applyStimulus(2'b11, '0, 1'b0, dummy);
        gotoEdge(e4 + 6);
        checkOutput("t3_no_press", 32'(BtnPress), 32'h0);
        gotoEdge(e4 + 12);
        checkOutput("t3_level", 32'(BtnLevel), 32'h0);
        checkOutput("t3_no_release", 32'(BtnRelease), 32'h0);

        $display("[TB] switch 3 change and switch 7 glitch");
        applyStimulus(2'b11, 10'h008, 1'b0, e5);
        gotoEdge(e5 + 5);
        checkOutput("t5_change_early", 32'(SwChange), 32'h0);
        gotoEdge(e5 + 6);
        checkOutput("t5_change", 32'(SwChange), 32'h008);
        checkOutput("t5_level", 32'(SwLevel), 32'h008);
        gotoEdge(e5 + 7);
        checkOutput("t5_change_once", 32'(SwChange), 32'h0);
        applyStimulus(2'b11, 10'h088, 1'b0, e6);
        gotoEdge(e6 + 1);
        applyStimulus(2'b11, 10'h008, 1'b0, dummy);
        gotoEdge(e6 + 10);
        checkOutput("t5_glitch_level", 32'(SwLevel), 32'h008);
        checkOutput("t5_glitch_change", 32'(SwChange), 32'h0);

        $display("[TB] reset in PRESS_WAIT and in PRESSED");
        applyStimulus(2'b10, 10'h008, 1'b0, e7);
        gotoEdge(e7 + 3);
        applyStimulus(2'b10, 10'h008, 1'b1, dummy);
        gotoEdge(e7 + 4);
        checkOutput("t6_rst_level", 32'(BtnLevel), 32'h0);
        checkOutput("t6_rst_press", 32'(BtnPress), 32'h0);
        checkOutput("t6_rst_swlevel", 32'(SwLevel), 32'h0);
        checkOutput("t6_rst_swchange", 32'(SwChange), 32'h0);
        applyStimulus(2'b10, 10'h008, 1'b0, e8);
        gotoEdge(e8 + 5);
        checkOutput("t6_repress_early", 32'(BtnPress), 32'h0);
        gotoEdge(e8 + 6);
        checkOutput("t6_repress", 32'(BtnPress), 32'h1);
        checkOutput("t6_repress_level", 32'(BtnLevel), 32'h1);
        checkOutput("t6_sw_after_rst", 32'(SwChange), 32'h008);
        gotoEdge(e8 + 10);
        applyStimulus(2'b10, 10'h008, 1'b1, dummy);
        gotoEdge(e8 + 11);
        checkOutput("t6_rst2_level", 32'(BtnLevel), 32'h0);
        checkOutput("t6_rst2_long", 32'(BtnLong), 32'h0);
        checkOutput("t6_rst2_swlevel", 32'(SwLevel), 32'h0);
        applyStimulus(2'b11, '0, 1'b0, dummy);
        gotoEdge(e8 + 25);
        checkOutput("t6_quiet_level", 32'(BtnLevel), 32'h0);
        checkOutput("t6_quiet_release", 32'(BtnRelease), 32'h0);
        checkOutput("t6_quiet_swlevel", 32'(SwLevel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
